instruction_fetch: RTL
======================

# instruction_fetch

- Fetch stage of the MIPS pipeline.
- Drives `readAddress` into `instruction_memory` and tags each returned word with its PC. Memory read is synchronous, so data arrives one cycle after the address is sampled.
- Presents a registered `fetchedInstruction`/`fetchedPC`/`fetchValid` triple to decode.
- Handles decode stalls with a one-entry skid buffer, so stalls cost zero bubbles. Handles branch redirects with a squash.

## Interface

Parameters:
- `ADDR_WIDTH`, 10, byte-address width; matches `instruction_memory`.
- `INSTR_WIDTH`, 32, instruction width.
- `RESET_PC`, 0, first fetch address; word-aligned.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `readAddress`  out  ADDR_WIDTH  address to `instruction_memory`.
- `instruction`  in  INSTR_WIDTH  memory data; equals mem[readAddress sampled at previous edge].
- `stall`  in  1  decode not accepting; fetch outputs must hold.
- `branchTaken`  in  1  redirect request, one-cycle pulse.
- `branchTarget`  in  ADDR_WIDTH  redirect address; bits [1:0] forced to 0.
- `fetchedInstruction`  out  INSTR_WIDTH  instruction to decode.
- `fetchedPC`  out  ADDR_WIDTH  address of `fetchedInstruction`.
- `fetchValid`  out  1  output triple is a real instruction.

## Operation

Internal registers:
- `tagPC`: address whose data is on `instruction` this cycle.
- `inFlight`: that data is valid (not squashed).
- `skidInstr`, `skidPC`, `skidValid`: skid buffer.
- `state`: RUN or SKID.

Reset (every edge with `reset`=1):
- `readAddress`=RESET_PC.
- `tagPC`=0, `inFlight`=0.
- `fetchedInstruction`=0, `fetchedPC`=0, `fetchValid`=0.
- Skid cleared, `state`=RUN.

Priority per edge: `reset` > `branchTaken` > `stall` > normal.

Branch (any state):
- `readAddress`←{`branchTarget`[ADDR_WIDTH-1:2],2'b00}.
- `inFlight`←0, `skidValid`←0, `fetchValid`←0, `state`←RUN.
- Overrides a simultaneous stall.

RUN, `stall`=0:
- Output triple ← {`instruction`, `tagPC`, `inFlight`}.
- `tagPC`←`readAddress`, `inFlight`←1.
- `readAddress`←`readAddress`+4.

RUN, `stall`=1:
- Outputs hold, `readAddress` holds.
- Skid ← {`instruction`, `tagPC`, `inFlight`}; `state`←SKID.

SKID, `stall`=1:
- Everything holds.
- Memory keeps re-reading `readAddress`.

SKID, `stall`=0:
- Output triple ← skid.
- `tagPC`←`readAddress`, `inFlight`←1.
- `readAddress`←`readAddress`+4, `state`←RUN.
- This is correct because memory sampled the held `readAddress` on this edge.

Arithmetic: PC increment is modulo 2^ADDR_WIDTH (1020+4→0 at width 10). There are no misaligned PCs.

## Timing

- Address-to-output latency is 2 cycles: address issued at edge n, memory data at n+1, output registered at n+2.
- After reset deasserts at edge R: `readAddress` = RESET_PC during cycle R. First `fetchValid`=1 (PC RESET_PC) appears after edge R+2.
- Steady state: one instruction per cycle, consecutive PCs.
- Stall of any length N≥1:
  - Outputs frozen N cycles.
  - The cycle after release shows the next sequential PC; zero bubbles, no duplicates, no skips.
- Branch at edge B: `fetchValid`=0 after B and B+1. Target appears after B+2, then target+4, and so on.
- Reset mid-stall or mid-branch: full reset values on the next edge; skid discarded.
- `readAddress` is a register output with no combinational path from any input.

## Structure

- Shared package/header `mips_defs`: ADDR_WIDTH, INSTR_WIDTH, PC_STEP=4, RUN/SKID state encodings.
- Natural sub-module: `fetch_skid_buffer`, a one-entry instruction+PC+valid holding register with load/clear.
- Everything else (PC register, FSM, output register) lives in `instruction_fetch`.

## Test plan

The bench uses `instruction_memory` preloaded so that the word at byte address a = 32'hA000_0000 | a.

- Reset with RESET_PC=0 for 2 cycles, then release → `readAddress` 0,4,8 on successive cycles; `fetchValid` rises after the second edge with `fetchedPC`=0 / 32'hA000_0000, then 4, 8, 12 back-to-back.
- Stall=1 for exactly one cycle while `fetchedPC`=8 → 8 held for 2 cycles, then 12, 16; no gap, no duplicate.
- Stall=1 for 5 cycles while `fetchedPC`=20 → `readAddress` constant for 5 cycles, outputs frozen at 20, then 24, 28 contiguous.
- Branch pulse to 102 → `fetchValid`=0 for 2 cycles; then `fetchedPC`=100 / 32'hA000_0064, then 104.
- Branch to 1016 asserted together with stall → branch wins; 1016, 1020, 0, 4 with `fetchValid`=1 (wrap).
- Reset asserted on the third cycle of a stall → next cycle all outputs 0, `readAddress`=RESET_PC; sequence restarts as in the first scenario.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS pipeline constants and fetch FSM encoding.
// Pure declarations: no logic, no latency, no flow control.
// Widths here are the defaults picked up by the fetch stage parameters.
package mips_defs;

   localparam int ADDR_WIDTH  = 10;
   localparam int INSTR_WIDTH = 32;
   localparam int PC_STEP     = 4;

   typedef enum logic {
      RUN  = 1'b0,
      SKID = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction, its PC and its valid bit.
// Latency: captured on the edge where load is high, visible the next cycle.
// No flow control of its own; the owner decides when to load or clear.
module fetch_skid_buffer #(
   parameter int ADDR_WIDTH  = mips_defs::ADDR_WIDTH,
   parameter int INSTR_WIDTH = mips_defs::INSTR_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   load,
   input  logic [INSTR_WIDTH-1:0] loadInstr,
   input  logic [ADDR_WIDTH-1:0]  loadPC,
   input  logic                   loadValid,
   output logic [INSTR_WIDTH-1:0] skidInstr,
   output logic [ADDR_WIDTH-1:0]  skidPC,
   output logic                   skidValid
);

   // Clear only drops the valid bit; a stale payload is never observed
   // because nothing reads it without a fresh load first.
   always_ff @(posedge clk) begin
      if (reset) begin
         skidInstr <= '0;
         skidPC    <= '0;
         skidValid <= 1'b0;
      end else if (clear) begin
         skidValid <= 1'b0;
      end else if (load) begin
         skidInstr <= loadInstr;
         skidPC    <= loadPC;
         skidValid <= loadValid;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: drives instruction memory and tags each returned word with its PC.
// Latency: 2 cycles from address issue to registered output; one instruction per cycle.
// Backpressure: decode stall freezes outputs; a one-entry skid holds the in-flight word.
module instruction_fetch
   import mips_defs::*;
#(
   parameter int                      ADDR_WIDTH  = mips_defs::ADDR_WIDTH,
   parameter int                      INSTR_WIDTH = mips_defs::INSTR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [ADDR_WIDTH-1:0]  readAddress,
   input  logic [INSTR_WIDTH-1:0] instruction,
   input  logic                   stall,
   input  logic                   branchTaken,
   input  logic [ADDR_WIDTH-1:0]  branchTarget,
   output logic [INSTR_WIDTH-1:0] fetchedInstruction,
   output logic [ADDR_WIDTH-1:0]  fetchedPC,
   output logic                   fetchValid
);

   fetch_state_t state, nextState;

   logic [ADDR_WIDTH-1:0]  tagPC;
   logic                   inFlight;
   logic [ADDR_WIDTH-1:0]  branchAligned;

   logic                   skidLoad;
   logic                   skidClear;
   logic                   advance;
   logic                   useSkid;
   logic [INSTR_WIDTH-1:0] skidInstr;
   logic [ADDR_WIDTH-1:0]  skidPC;
   logic                   skidValid;

   assign branchAligned = branchTarget & ~ADDR_WIDTH'(3);

   fetch_skid_buffer #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .clear     (skidClear),
      .load      (skidLoad),
      .loadInstr (instruction),
      .loadPC    (tagPC),
      .loadValid (inFlight),
      .skidInstr (skidInstr),
      .skidPC    (skidPC),
      .skidValid (skidValid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      skidLoad  = 1'b0;
      skidClear = 1'b0;
      advance   = 1'b0;
      useSkid   = 1'b0;
      if (branchTaken) begin
         nextState = RUN;
         skidClear = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (stall) begin
                  skidLoad  = 1'b1;
                  nextState = SKID;
               end else begin
                  advance = 1'b1;
               end
            end
            SKID: begin
               // Memory re-read readAddress throughout the stall, so releasing
               // from the skid can advance the PC exactly as in RUN.
               if (!stall) begin
                  advance   = 1'b1;
                  useSkid   = 1'b1;
                  nextState = RUN;
               end
            end
            default: nextState = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readAddress        <= RESET_PC;
         tagPC              <= '0;
         inFlight           <= 1'b0;
         fetchedInstruction <= '0;
         fetchedPC          <= '0;
         fetchValid         <= 1'b0;
      end else if (branchTaken) begin
         readAddress <= branchAligned;
         inFlight    <= 1'b0;
         fetchValid  <= 1'b0;
      end else if (advance) begin
         if (useSkid) begin
            fetchedInstruction <= skidInstr;
            fetchedPC          <= skidPC;
            fetchValid         <= skidValid;
         end else begin
            fetchedInstruction <= instruction;
            fetchedPC          <= tagPC;
            fetchValid         <= inFlight;
         end
         tagPC       <= readAddress;
         inFlight    <= 1'b1;
         readAddress <= readAddress + ADDR_WIDTH'(PC_STEP);
      end
   end

endmodule
